pcu_multi: RTL
==============

Name: pcu_multi

Overview:
- Parametrised pipeline control unit: hazard detection plus forwarding control for an in-order core with DEPTH post-decode stages and NUM_SRC source operands per instruction.
- Sits beside the ID stage and tracks a shadow copy of every downstream pipeline register.
- Drives per-register stall/clear vectors and per-operand forward selects.
- Additions: load-use stalls with configurable load latency, branch flush, external freeze, x0 exclusion and saturating hazard counters.

Parameters:
- ADDR_WIDTH, 5, register address width.
- NUM_SRC, 2, source operands checked per instruction.
- DEPTH, 3, shadowed stages after ID; stage 1 = EX, stage DEPTH = WB; legal range 1..7.
- LOAD_LAT, 1, first stage index whose load result is forwardable is LOAD_LAT+1; legal range 1..DEPTH-1.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- instr_type_i  in  decoded_opcode  class of the instruction in ID.
- src_use_i  in  NUM_SRC  operand s is read by the instruction in ID.
- src_addr_i  in  NUM_SRC x ADDR_WIDTH  source register addresses.
- write_addr_i  in  ADDR_WIDTH  destination of the instruction in ID.
- write_en_i  in  1  instruction in ID writes the register file.
- branch_flush_i  in  1  taken branch/jump resolved in EX.
- mem_stall_i  in  1  external memory wait; freezes the whole pipe.
- stall_o  out  DEPTH+1  stall_o[k] holds the register feeding stage k; index 0 = IF/ID and PC.
- clear_o  out  DEPTH+1  clear_o[k] loads a bubble into the register feeding stage k.
- fwd_sel_o  out  NUM_SRC x 3  per operand: 0 = register file, k = forward from stage k.
- load_use_hazard_o  out  1  load-use stall is active this cycle.
- stall_cnt_o  out  CNT_WIDTH  cycles lost to load-use stalls.
- flush_cnt_o  out  CNT_WIDTH  branch flushes taken.

Behaviour:
- Shadow stage k (1..DEPTH) holds {instr_type, write_addr, write_en}. It follows pipeline register k: hold if stall_o[k], bubble (OP_NO_OP, write_en=0) if clear_o[k], else copy stage k-1. Stage 0 is the combinational ID inputs.
- Reset (synchronous, rst=1 at a clk edge): all shadow stages become bubbles and both counters become 0.
- Outputs while rst is high: stall_o=0, clear_o=all ones, fwd_sel_o=0, load_use_hazard_o=0.
- Match rule for operand s: src_use_i[s]=1, src_addr_i[s]!=0, stage write_en=1 and write_addr==src_addr_i[s]. Register x0 is never forwarded and never causes a hazard.
- fwd_sel_o[s] is the smallest matching k in 1..DEPTH (youngest producer wins), else 0. It is purely combinational, with no cycle of latency.
- Load-use hazard: for some s, the youngest match is at stage k<=LOAD_LAT and that stage holds OP_LOAD. A younger non-load match shadows an older load, so no hazard arises in that case.
- Priority each cycle: rst > mem_stall_i > branch_flush_i > load-use > normal.
  - mem_stall_i: stall_o=all ones, clear_o=0, hazard output 0, no counter change.
  - branch_flush_i: clear_o[0]=clear_o[1]=1. All other bits are 0, so stages 2..DEPTH advance. flush_cnt_o increments. Any load-use condition is suppressed.
  - Load-use: stall_o[0]=1, clear_o[1]=1, load_use_hazard_o=1, fwd_sel_o forced 0, stall_cnt_o increments. Stages 2..DEPTH advance. The condition re-evaluates every cycle, so a load in stage 1 with LOAD_LAT=2 stalls for 2 cycles.
  - Normal: stall_o=0, clear_o=0.
- Counters saturate at all ones and never wrap.
- Reset mid-stall: the next cycle starts hazard-free, because all shadow stages hold bubbles.

Decomposition:
- Shared package (riscv_defines or pcu_pkg): stage_state struct, FWD_SEL_W constant (3), bubble constant (OP_NO_OP, write_en=0).
- One sub-module, pcu_fwd_match, instantiated NUM_SRC times. It takes one operand plus the shadow array and returns the youngest match index plus an is_load flag.

Test Plan:
- Reset: hold rst 2 cycles with a matching producer on the inputs -> clear_o=4'b1111, fwd_sel_o=0; after release, counters read 0 and no forward for 1 cycle.
- ADD x5 then ADD x6,x5,x5 -> fwd_sel_o[0]=fwd_sel_o[1]=1. One gap instruction -> 2; two gap instructions -> 3; three gap instructions -> 0.
- LW x7 then ADD x8,x7,x0 (LOAD_LAT=1) -> 1 cycle with stall_o[0]=1, clear_o[1]=1, hazard=1, stall_cnt_o=1; next cycle fwd_sel_o[0]=2.
- Same sequence with LOAD_LAT=2 -> 2 stall cycles, then fwd_sel_o[0]=3, stall_cnt_o=2. Variant: ADD x0 producer with a consumer reading x0 -> fwd 0, no stall.
- Load-use pending and branch_flush_i=1 in the same cycle -> clear_o[1:0]=2'b11, hazard=0, flush_cnt_o=1, stall_cnt_o unchanged. With mem_stall_i also 1 -> stall_o all ones, clear_o=0, no counter change.
- Force stall_cnt_o to all ones (CNT_WIDTH=4, 20 load-use stalls) -> counter stays at 4'hF.

Source files
------------

// File: rtl/pcu_multi_pkg.sv
// Shared types for the pipeline control unit: opcode classes, shadow-stage record
// and the bubble written into a cleared stage.
package pcu_multi_pkg;

    localparam int FWD_SEL_W  = 3;
    localparam int ADDR_W_MAX = 8;

    typedef enum logic [2:0] {
        OP_NO_OP  = 3'd0,
        OP_ALU    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_JUMP   = 3'd5
    } decoded_opcode;

    // Addresses are zero-extended to ADDR_W_MAX so one record serves every ADDR_WIDTH.
    typedef struct packed {
        decoded_opcode           instr_type;
        logic [ADDR_W_MAX-1:0]   write_addr;
        logic                    write_en;
    } stage_state_t;

    localparam stage_state_t BUBBLE = '{instr_type: OP_NO_OP, write_addr: '0, write_en: 1'b0};

endpackage

// File: rtl/pcu_multi_if.sv
// ID-stage handshake between the core (master) and the pipeline control unit (slave).
interface pcu_multi_if
    import pcu_multi_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int CNT_WIDTH  = 16
);
    decoded_opcode                             instr_type_i;
    logic [NUM_SRC-1:0]                        src_use_i;
    logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]        src_addr_i;
    logic [ADDR_WIDTH-1:0]                     write_addr_i;
    logic                                      write_en_i;
    logic                                      branch_flush_i;
    logic                                      mem_stall_i;
    logic [DEPTH:0]                            stall_o;
    logic [DEPTH:0]                            clear_o;
    logic [NUM_SRC-1:0][FWD_SEL_W-1:0]         fwd_sel_o;
    logic                                      load_use_hazard_o;
    logic [CNT_WIDTH-1:0]                      stall_cnt_o;
    logic [CNT_WIDTH-1:0]                      flush_cnt_o;

    modport master (
        output instr_type_i, src_use_i, src_addr_i, write_addr_i, write_en_i,
               branch_flush_i, mem_stall_i,
        input  stall_o, clear_o, fwd_sel_o, load_use_hazard_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  instr_type_i, src_use_i, src_addr_i, write_addr_i, write_en_i,
               branch_flush_i, mem_stall_i,
        output stall_o, clear_o, fwd_sel_o, load_use_hazard_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pcu_multi_fwd_match.sv
// Finds the youngest shadow stage that produces one source operand and flags whether
// that producer is a load.
module pcu_fwd_match
    import pcu_multi_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                      src_use,
    input  logic [ADDR_W_MAX-1:0]     src_addr,
    input  stage_state_t [DEPTH:1]    shadow,
    output logic [FWD_SEL_W-1:0]      match_k,
    output logic                      is_load
);

    // Scanning oldest to youngest lets the youngest producer overwrite older ones.
    always_comb begin
        match_k = '0;
        is_load = 1'b0;
        if (src_use && (src_addr != '0)) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (shadow[k].write_en && (shadow[k].write_addr == src_addr)) begin
                    match_k = FWD_SEL_W'(k);
                    is_load = (shadow[k].instr_type == OP_LOAD);
                end
            end
        end
    end

endmodule

// File: rtl/pcu_multi.sv
// Pipeline control unit: shadows DEPTH post-decode stages, resolves forwarding and
// load-use hazards, and applies freeze/flush/stall priority with saturating counters.
module pcu_multi
    import pcu_multi_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    pcu_multi_if.slave  bus
);

    stage_state_t [DEPTH:1]             shadow;
    stage_state_t                       id_entry;
    logic [NUM_SRC-1:0][FWD_SEL_W-1:0]  match_k;
    logic [NUM_SRC-1:0]                 match_load;
    logic [NUM_SRC-1:0]                 load_hit;
    logic                               load_use;
    logic [DEPTH:0]                     stall;
    logic [DEPTH:0]                     clear;
    logic                               flush_take;
    logic                               stall_take;
    logic [CNT_WIDTH-1:0]               stall_cnt;
    logic [CNT_WIDTH-1:0]               flush_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign id_entry = '{instr_type: bus.instr_type_i,
                        write_addr: ADDR_W_MAX'(bus.write_addr_i),
                        write_en:   bus.write_en_i};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        pcu_fwd_match #(.DEPTH(DEPTH)) u_match (
            .src_use  (bus.src_use_i[s]),
            .src_addr (ADDR_W_MAX'(bus.src_addr_i[s])),
            .shadow   (shadow),
            .match_k  (match_k[s]),
            .is_load  (match_load[s])
        );
        // A load is only a hazard while its result is not yet forwardable.
        assign load_hit[s] = match_load[s] && (match_k[s] <= FWD_SEL_W'(LOAD_LAT));
    end

    assign load_use = |load_hit;

    always_comb begin
        stall                 = '0;
        clear                 = '0;
        bus.fwd_sel_o         = match_k;
        bus.load_use_hazard_o = 1'b0;
        flush_take            = 1'b0;
        stall_take            = 1'b0;
        if (rst) begin
            clear         = '1;
            bus.fwd_sel_o = '0;
        end else if (bus.mem_stall_i) begin
            stall = '1;
        end else if (bus.branch_flush_i) begin
            clear[1:0] = 2'b11;
            flush_take = 1'b1;
        end else if (load_use) begin
            stall[0]              = 1'b1;
            clear[1]              = 1'b1;
            bus.fwd_sel_o         = '0;
            bus.load_use_hazard_o = 1'b1;
            stall_take            = 1'b1;
        end
    end

    // Shadow registers: follow the real pipeline registers' hold/bubble/advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) shadow[k] <= BUBBLE;
        end else begin
            if (!stall[1]) shadow[1] <= clear[1] ? BUBBLE : id_entry;
            for (int k = 2; k <= DEPTH; k++) begin
                if (!stall[k]) shadow[k] <= clear[k] ? BUBBLE : shadow[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_take) stall_cnt <= sat_inc(stall_cnt);
            if (flush_take) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign bus.stall_o     = stall;
    assign bus.clear_o     = clear;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;

endmodule
